// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID/EX/MEM hazard fields in, stall/flush/forward controls out.
interface pipeline_hazard_ctrl_if;
    logic [4:0] ID_rs, ID_rt;
    logic       ID_use_rs, ID_use_rt, ID_BrJr, ID_taken, ID_PC31;
    logic       EX_RegWr, EX_MemRd;
    logic [4:0] EX_WrReg;
    logic       MEM_RegWr, MEM_MemRd;
    logic [4:0] MEM_WrReg;
    logic       IRQ;
    logic       PC_stall, IFID_stall, IFID_flush, IDEX_flush;
    logic       ForwardC, ForwardD, irq_take;
    modport master (
        output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_BrJr, ID_taken, ID_PC31,
        output EX_RegWr, EX_MemRd, EX_WrReg, MEM_RegWr, MEM_MemRd, MEM_WrReg, IRQ,
        input  PC_stall, IFID_stall, IFID_flush, IDEX_flush, ForwardC, ForwardD, irq_take
    );
    modport slave (
        input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_BrJr, ID_taken, ID_PC31,
        input  EX_RegWr, EX_MemRd, EX_WrReg, MEM_RegWr, MEM_MemRd, MEM_WrReg, IRQ,
        output PC_stall, IFID_stall, IFID_flush, IDEX_flush, ForwardC, ForwardD, irq_take
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: ID-stage stall/flush/forward control with IRQ sequencing FSM.
module pipeline_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int IRQ_TMO = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);
    typedef enum logic [1:0] {S_RUN, S_PEND, S_TAKE, S_WAIT} state_t;
    state_t     state;
    logic [3:0] tmo;
    logic       ma, mb, ex_rs, ex_rt, mem_rs, mem_rt, hz_raw, stall, take, clean;
    assign ma     = hz.ID_use_rs & |hz.ID_rs;
    assign mb     = hz.ID_use_rt & |hz.ID_rt;
    assign ex_rs  = hz.EX_RegWr & |hz.EX_WrReg & (hz.EX_WrReg == hz.ID_rs);
    assign ex_rt  = hz.EX_RegWr & |hz.EX_WrReg & (hz.EX_WrReg == hz.ID_rt);
    assign mem_rs = hz.MEM_RegWr & |hz.MEM_WrReg & (hz.MEM_WrReg == hz.ID_rs);
    assign mem_rt = hz.MEM_RegWr & |hz.MEM_WrReg & (hz.MEM_WrReg == hz.ID_rt);
    assign hz_raw = (hz.EX_MemRd | hz.ID_BrJr) & (ma & ex_rs | mb & ex_rt)
                  | hz.ID_BrJr & hz.MEM_MemRd & (ma & mem_rs | mb & mem_rt);
    // every output is gated by reset so the reset cycle is fully quiet
    assign stall  = !reset & hz_raw;
    assign take   = !reset & !stall & (state == S_TAKE);
    assign clean  = !hz_raw & !hz.ID_taken & !hz.ID_BrJr;
    assign hz.PC_stall   = stall;
    assign hz.IFID_stall = stall;
    assign hz.IDEX_flush = stall | take;
    assign hz.IFID_flush = !reset & !stall & (take | hz.ID_taken);
    assign hz.irq_take   = take;
    assign hz.ForwardC   = !reset & ma & mem_rs & !hz.MEM_MemRd;
    assign hz.ForwardD   = !reset & mb & mem_rt & !hz.MEM_MemRd;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            tmo       <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (hz.IFID_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
            case (state)
                S_RUN:  if (hz.IRQ && !hz.ID_PC31) state <= S_PEND;
                S_PEND: state <= !hz.IRQ ? S_RUN : clean ? S_TAKE : S_PEND;
                S_TAKE: if (!stall) begin
                    state <= S_WAIT;
                    tmo   <= 4'd0;
                end
                default: begin
                    tmo <= tmo + 4'd1;
                    if (hz.ID_PC31 || tmo == 4'(IRQ_TMO)) state <= S_RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table plus IRQ/reset sequences, scoreboard-checked.
module tb_pipeline_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] stall_cnt, flush_cnt;
    always #5 clk = ~clk;
    pipeline_hazard_ctrl_if hz();
    pipeline_hazard_ctrl #(.CNT_W(32), .IRQ_TMO(15)) dut (
        .clk(clk), .reset(reset), .hz(hz.slave), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    typedef struct {
        logic rst; logic [4:0] rs, rt; logic ur, ut, br, tk, k;
        logic exw, exr; logic [4:0] exd; logic mw, mr; logic [4:0] md; logic irq;
        logic [6:0] exp;
    } vec_t;
    // expected order: PC_stall IFID_stall IFID_flush IDEX_flush ForwardC ForwardD irq_take
    logic [6:0] exp_q[$];
    string      name_q[$];
    int         checks = 0, errors = 0;
    vec_t       tbl[15];
    vec_t       v;
    task automatic check_out();
        logic [6:0] e, a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {hz.PC_stall, hz.IFID_stall, hz.IFID_flush, hz.IDEX_flush, hz.ForwardC, hz.ForwardD, hz.irq_take};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask
    task automatic step(input vec_t x, input string n);
        reset = x.rst;
        hz.ID_rs = x.rs; hz.ID_rt = x.rt; hz.ID_use_rs = x.ur; hz.ID_use_rt = x.ut;
        hz.ID_BrJr = x.br; hz.ID_taken = x.tk; hz.ID_PC31 = x.k;
        hz.EX_RegWr = x.exw; hz.EX_MemRd = x.exr; hz.EX_WrReg = x.exd;
        hz.MEM_RegWr = x.mw; hz.MEM_MemRd = x.mr; hz.MEM_WrReg = x.md; hz.IRQ = x.irq;
        exp_q.push_back(x.exp);
        name_q.push_back(n);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_cnt(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask
    function automatic vec_t mk(input logic irq, input logic k, input logic br, input logic [6:0] exp);
        return '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, br, 1'b0, k, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, irq, exp};
    endfunction
    initial begin
        // rst rs  rt  ur ut br tk k  exw exr exd mw mr md  irq exp
        tbl[0]  = '{0, 8,  0,  1, 0, 0, 0, 0, 1, 1, 8,  0, 0, 0,  0, 7'b1101000};
        tbl[1]  = '{0, 8,  0,  1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 8,  0, 7'b0000000};
        tbl[2]  = '{0, 9,  0,  1, 0, 1, 0, 0, 1, 0, 9,  0, 0, 0,  0, 7'b1101000};
        tbl[3]  = '{0, 9,  0,  1, 0, 1, 1, 0, 0, 0, 0,  1, 0, 9,  0, 7'b0010100};
        tbl[4]  = '{0, 0,  10, 0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 10, 0, 7'b1101000};
        tbl[5]  = '{0, 0,  0,  1, 1, 1, 0, 0, 1, 1, 0,  1, 1, 0,  0, 7'b0000000};
        tbl[6]  = '{0, 8,  0,  1, 0, 0, 1, 0, 1, 1, 8,  0, 0, 0,  0, 7'b1101000};
        tbl[7]  = '{0, 8,  11, 1, 1, 0, 0, 0, 1, 1, 8,  1, 0, 11, 0, 7'b1101010};
        tbl[8]  = '{0, 8,  0,  0, 0, 0, 0, 0, 1, 1, 8,  0, 0, 0,  0, 7'b0000000};
        tbl[9]  = '{0, 8,  0,  1, 0, 0, 0, 0, 0, 1, 8,  0, 0, 0,  0, 7'b0000000};
        tbl[10] = '{0, 9,  0,  1, 0, 0, 0, 0, 1, 0, 9,  0, 0, 0,  0, 7'b0000000};
        tbl[11] = '{0, 12, 0,  1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 12, 0, 7'b0000100};
        tbl[12] = '{0, 0,  0,  0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0,  0, 7'b0010000};
        tbl[13] = '{0, 3,  4,  1, 1, 1, 0, 0, 1, 0, 4,  0, 0, 0,  0, 7'b1101000};
        tbl[14] = '{0, 0,  10, 0, 1, 1, 0, 0, 0, 0, 0,  0, 1, 10, 0, 7'b0000000};
        // reset cycles with live hazards and forwarding must still read all-zero
        v = tbl[0]; v.rst = 1'b1; v.exp = '0;
        step(v, "reset_loaduse");
        v = tbl[11]; v.rst = 1'b1; v.irq = 1'b1; v.exp = '0;
        step(v, "reset_fwd");
        chk_cnt("reset_stall_cnt", stall_cnt, 0);
        chk_cnt("reset_flush_cnt", flush_cnt, 0);
        for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("vec%0d", i));
        chk_cnt("tbl_stall_cnt", stall_cnt, 6);
        chk_cnt("tbl_flush_cnt", flush_cnt, 2);
        // IRQ deferred while a branch sits in ID, taken on the first clean slot
        step(mk(1, 0, 1, 7'b0), "irq_run_br");
        step(mk(1, 0, 1, 7'b0), "pend_br");
        v = tbl[0]; v.irq = 1'b1;
        step(v, "pend_stall");
        step(mk(1, 0, 0, 7'b0), "pend_clean");
        step(mk(1, 0, 0, 7'b0011001), "take");
        step(mk(1, 0, 0, 7'b0), "wait_ignore");
        step(mk(1, 1, 0, 7'b0), "wait_kernel");
        step(mk(0, 0, 0, 7'b0), "run_idle");
        chk_cnt("irq_stall_cnt", stall_cnt, 7);
        chk_cnt("irq_flush_cnt", flush_cnt, 3);
        // timeout: 16 WAIT cycles (tmo 0..15), then RUN->PEND->TAKE again
        step(mk(1, 0, 0, 7'b0), "rerun_pend");
        step(mk(1, 0, 0, 7'b0), "rerun_take_next");
        step(mk(1, 0, 0, 7'b0011001), "take2");
        for (int i = 0; i < 18; i++) step(mk(1, 0, 0, 7'b0), $sformatf("tmo_wait%0d", i));
        step(mk(1, 0, 0, 7'b0011001), "take_after_tmo");
        chk_cnt("tmo_flush_cnt", flush_cnt, 5);
        // IRQ dropped in PEND: nothing taken
        step(mk(0, 1, 0, 7'b0), "wait_exit");
        step(mk(1, 0, 1, 7'b0), "pend_enter");
        step(mk(0, 0, 0, 7'b0), "pend_drop");
        step(mk(0, 0, 0, 7'b0), "after_drop0");
        step(mk(0, 0, 0, 7'b0), "after_drop1");
        // reset during TAKE abandons the IRQ
        step(mk(1, 0, 0, 7'b0), "pre_pend");
        step(mk(1, 0, 0, 7'b0), "pre_take");
        v = mk(1, 0, 0, 7'b0); v.rst = 1'b1;
        step(v, "reset_in_take");
        step(mk(0, 0, 0, 7'b0), "post_reset");
        chk_cnt("post_reset_stall_cnt", stall_cnt, 0);
        chk_cnt("post_reset_flush_cnt", flush_cnt, 0);
        step(mk(1, 0, 0, 7'b0), "post_reset_pend");
        step(mk(1, 0, 0, 7'b0), "post_reset_clean");
        step(mk(0, 0, 0, 7'b0011001), "post_reset_take");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
